icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_tagram.sv | 52 +++++
 rtl/icache.sv | 153 +++++++++++++++
 tb/tb_icache.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
// Used by icache and icache_tagram.
package icache_pkg;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_REFILL = 1'b1
    } state_e;

    localparam int DEF_NLINES    = 16;
    localparam int DEF_LINEWORDS = 4;

    function automatic int off_w(input int linewords);
        return $clog2(linewords);
    endfunction

    function automatic int idx_w(input int nlines);
        return $clog2(nlines);
    endfunction

    function automatic int tag_w(input int nlines, input int linewords);
        return 32 - 2 - $clog2(linewords) - $clog2(nlines);
    endfunction

endpackage

// File: rtl/icache_tagram.sv
// Valid/tag/data storage: combinational read, synchronous write, one-cycle
// clear of every valid bit. Data and tag arrays carry no reset.
module icache_tagram import icache_pkg::*; #(
    parameter int NLINES    = DEF_NLINES,
    parameter int LINEWORDS = DEF_LINEWORDS,
    localparam int OFFW = off_w(LINEWORDS),
    localparam int IDXW = idx_w(NLINES),
    localparam int TAGW = tag_w(NLINES, LINEWORDS)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            clear_i,
    input  logic [IDXW-1:0] rd_idx_i,
    input  logic [OFFW-1:0] rd_off_i,
    output logic            rd_valid_o,
    output logic [TAGW-1:0] rd_tag_o,
    output logic [31:0]     rd_data_o,
    input  logic            word_we_i,
    input  logic [IDXW-1:0] wr_idx_i,
    input  logic [OFFW-1:0] wr_off_i,
    input  logic [31:0]     wr_data_i,
    input  logic            line_we_i,
    input  logic [TAGW-1:0] wr_tag_i
);

    logic [NLINES-1:0] valid_q;
    logic [TAGW-1:0]   tag_q  [NLINES];
    logic [31:0]       data_q [NLINES][LINEWORDS];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

    // Clear wins over validation so a flushed refill never leaves a live line.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            valid_q <= '0;
        end else if (line_we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (word_we_i) begin
            data_q[wr_idx_i][wr_off_i] <= wr_data_i;
        end
        if (line_we_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with zero-latency hits and a word-serial
// refill FSM. Optional hit/miss counters are enabled by ICACHE_PERF_EN.
module icache import icache_pkg::*; #(
    parameter int NLINES    = DEF_NLINES,
    parameter int LINEWORDS = DEF_LINEWORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcF,
    output logic [31:0] instrF,
    output logic        missF,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata,
    output state_e      dbg_state_o
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OFFW = off_w(LINEWORDS);
    localparam int IDXW = idx_w(NLINES);
    localparam int TAGW = tag_w(NLINES, LINEWORDS);

    state_e          state_q;
    logic [OFFW-1:0] k_q;
    logic            flush_pend_q;
    logic            mem_req_q;
    logic [31:0]     mem_addr_q;
    logic [IDXW-1:0] idx_q;
    logic [TAGW-1:0] tag_q;

    logic [OFFW-1:0] pc_off;
    logic [IDXW-1:0] pc_idx;
    logic [TAGW-1:0] pc_tag;
    logic [31:0]     line_base;
    logic            rd_valid;
    logic [TAGW-1:0] rd_tag;
    logic            hit;
    logic            word_we;
    logic            last_word;
    logic            drop_line;
    logic            clear_all;
    logic            line_we;
    logic            unused_pc;

    assign pc_off    = pcF[2 +: OFFW];
    assign pc_idx    = pcF[2+OFFW +: IDXW];
    assign pc_tag    = pcF[31 -: TAGW];
    assign line_base = {pcF[31:OFFW+2], {(OFFW+2){1'b0}}};
    assign unused_pc = ^pcF[1:0];

    assign hit       = (state_q == S_IDLE) && rd_valid && (rd_tag == pc_tag);
    assign missF     = !hit;
    assign word_we   = (state_q == S_REFILL) && mem_valid;
    assign last_word = word_we && (k_q == OFFW'(LINEWORDS - 1));
    // A flush seen on the final beat is treated like one that arrived earlier.
    assign drop_line = flush_pend_q || flush;
    assign clear_all = ((state_q == S_IDLE) && flush) || (last_word && drop_line);
    assign line_we   = last_word && !drop_line;

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign dbg_state_o = state_q;

    icache_tagram #(
        .NLINES    (NLINES),
        .LINEWORDS (LINEWORDS)
    ) u_tagram (
        .clk_i      (clk),
        .reset_i    (reset),
        .clear_i    (clear_all),
        .rd_idx_i   (pc_idx),
        .rd_off_i   (pc_off),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (instrF),
        .word_we_i  (word_we),
        .wr_idx_i   (idx_q),
        .wr_off_i   (k_q),
        .wr_data_i  (mem_rdata),
        .line_we_i  (line_we),
        .wr_tag_i   (tag_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            flush_pend_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            idx_q        <= '0;
            tag_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    flush_pend_q <= 1'b0;
                    if (!hit && !flush) begin
                        state_q    <= S_REFILL;
                        k_q        <= '0;
                        idx_q      <= pc_idx;
                        tag_q      <= pc_tag;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= line_base;
                    end
                end
                S_REFILL: begin
                    if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (mem_valid) begin
                        k_q        <= k_q + OFFW'(1);
                        mem_addr_q <= mem_addr_q + 32'd4;
                        if (last_word) begin
                            state_q      <= S_IDLE;
                            mem_req_q    <= 1'b0;
                            flush_pend_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if ((state_q == S_IDLE) && !hit && !flush) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hits, conflict eviction, redirect
// during refill, flush in IDLE and REFILL, reset mid-refill, optional counters.
module tb_icache;
  import icache_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        missF;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  state_e      dbg_state;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_checks;
  int n_fail;
  logic all_ones;

  icache dut (
    .clk        (clk),
    .reset      (reset),
    .pcF        (pcF),
    .instrF     (instrF),
    .missF      (missF),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_rdata  (mem_rdata),
    .dbg_state_o(dbg_state)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word n of the line at base B reads 0x1000 + B[31:8]<<8 + n
  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'h1000 + {a[31:8], 8'h00} + {28'h0, a[3:2]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // memory responder: each word is returned after two waiting cycles
  task automatic serve(input logic [31:0] base, input int first, input int n);
    logic [31:0] addr;
    for (int w = first; w < first + n; w++) begin
      addr = base + 32'(4 * w);
      for (int c = 0; c < 2; c++) begin
        check("mem_req_refill", {31'b0, mem_req}, 32'd1);
        check("mem_addr", mem_addr, addr);
        check("missF_refill", {31'b0, missF}, 32'd1);
        step();
      end
      mem_valid = 1'b1;
      mem_rdata = all_ones ? 32'hFFFF_FFFF : memword(addr);
      step();
      mem_valid = 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    all_ones  = 1'b0;
    reset     = 1'b1;
    pcF       = 32'h0;
    flush     = 1'b0;
    mem_valid = 1'b0;
    mem_rdata = 32'h0;

    // reset state
    step();
    step();
    check("reset_mem_req", {31'b0, mem_req}, 32'd0);
    check("reset_state", 32'(dbg_state), 32'(S_IDLE));
`ifdef ICACHE_PERF_EN
    check("reset_hit_count", hit_count, 32'd0);
    check("reset_miss_count", miss_count, 32'd0);
`endif
    reset = 1'b0;

    // cold miss at 0x10
    pcF = 32'h10;
    #1;
    check("cold_missF", {31'b0, missF}, 32'd1);
    step();
    check("cold_state", 32'(dbg_state), 32'(S_REFILL));
    serve(32'h10, 0, 4);
    check("cold_done_mem_req", {31'b0, mem_req}, 32'd0);
    check("cold_hit_missF", {31'b0, missF}, 32'd0);
    check("cold_hit_instr", instrF, 32'h1000);

    // same-line hits, stray mem_valid ignored
    pcF = 32'h1C;
    #1;
    check("hit1c_instr", instrF, 32'h1003);
    check("hit1c_missF", {31'b0, missF}, 32'd0);
    check("hit1c_mem_req", {31'b0, mem_req}, 32'd0);
    pcF = 32'h14;
    #1;
    check("hit14_instr", instrF, 32'h1001);
    step();
    mem_valid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_valid = 1'b0;
    check("stray_valid_instr", instrF, 32'h1001);
    check("stray_valid_mem_req", {31'b0, mem_req}, 32'd0);
    check("stray_valid_state", 32'(dbg_state), 32'(S_IDLE));
`ifdef ICACHE_PERF_EN
    check("perf_miss_count", miss_count, 32'd1);
    check("perf_hit_count", hit_count, 32'd2);
`endif

    // conflict: 0x110 evicts 0x10
    pcF = 32'h110;
    #1;
    check("conflict_missF", {31'b0, missF}, 32'd1);
    step();
    serve(32'h110, 0, 4);
    check("conflict_instr", instrF, 32'h1100);
    pcF = 32'h118;
    #1;
    check("conflict_instr2", instrF, 32'h1102);
    pcF = 32'h10;
    #1;
    check("evicted_missF", {31'b0, missF}, 32'd1);
    step();
    serve(32'h10, 0, 4);
    check("restore_instr", instrF, 32'h1000);

    // pcF redirected during refill of 0x20
    pcF = 32'h20;
    step();
    pcF = 32'h10;
    serve(32'h20, 0, 4);
    check("redirect_instr", instrF, 32'h1000);
    check("redirect_missF", {31'b0, missF}, 32'd0);
    pcF = 32'h24;
    #1;
    check("redirect_line_instr", instrF, 32'h1001);

    // all-ones refill data
    all_ones = 1'b1;
    pcF = 32'h30;
    step();
    serve(32'h30, 0, 4);
    all_ones = 1'b0;
    check("ones_instr", instrF, 32'hFFFF_FFFF);
    check("ones_missF", {31'b0, missF}, 32'd0);

    // flush in IDLE together with a miss
    pcF = 32'h10;
    #1;
    check("preflush_instr", instrF, 32'h1000);
    pcF = 32'h40;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_idle_mem_req", {31'b0, mem_req}, 32'd0);
    check("flush_idle_state", 32'(dbg_state), 32'(S_IDLE));
    pcF = 32'h10;
    #1;
    check("flush_idle_missF", {31'b0, missF}, 32'd1);
    step();
    serve(32'h10, 0, 4);
    check("postflush_instr", instrF, 32'h1000);

    // flush during refill at k=1
    pcF = 32'h50;
    step();
    serve(32'h50, 0, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    serve(32'h50, 1, 3);
    check("flush_refill_missF", {31'b0, missF}, 32'd1);
    check("flush_refill_mem_req", {31'b0, mem_req}, 32'd0);
    step();
    check("flush_refill_restart", {31'b0, mem_req}, 32'd1);
    check("flush_refill_addr", mem_addr, 32'h50);
    serve(32'h50, 0, 4);
    check("flush_refill_instr", instrF, 32'h1000);
    pcF = 32'h10;
    #1;
    check("flush_refill_other_missF", {31'b0, missF}, 32'd1);

    // reset during refill at k=2
    pcF = 32'h60;
    step();
    serve(32'h60, 0, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_mid_missF", {31'b0, missF}, 32'd1);
    step();
    serve(32'h60, 0, 4);
    check("rst_mid_refill_instr", instrF, 32'h1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
